int_arbiter: RTL and testbench

//  Interrupt arbiter between the peripheral IRQ lines (ETH, I2C x2, SPI x2, EXT) and the single CPU INT/INT_ACK pair.
//  - Captures rising edges into a pending register and applies a mask.
//  - Picks one winner and holds INT with its ID until INT_ACK.
//  - Returns a 1-cycle ACK pulse to the winning source.
//  - Sits behind a Core-B slave wrapper using the slave-core REQ/WT/ADDR/WDT/RDT/nWAIT interface.

---
 rtl/int_arbiter.sv | 259 +++++++++++++++++++++++++
 tb/tb_int_arbiter.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/int_arbiter.sv
// ============================================================================
//  Module   : int_arbiter
//  Purpose  : Interrupt arbiter that captures IRQ edges, masks and arbitrates
//             them, and drives one CPU INT/INT_ACK pair with a slave register
//             port. Option INTARB_RR_EN selects round-robin arbitration.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module int_arbiter #(
    parameter int NSRC = 6,
    parameter int IDW  = 4
) (
    input  logic            CLK,
    input  logic            nRST,
    input  logic            REQ,
    input  logic            WT,
    input  logic [1:0]      ADDR,
    input  logic [31:0]     WDT,
    output logic [31:0]     RDT,
    output logic            nWAIT,
    input  logic [NSRC-1:0] SRC_INT,
    output logic [NSRC-1:0] SRC_ACK,
    output logic            INT,
    output logic [IDW-1:0]  INT_ID,
    input  logic            INT_ACK
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ASRT = 2'd1,
        S_ACKS = 2'd2
    } state_t;

    localparam logic [1:0] A_PEND = 2'd0;
    localparam logic [1:0] A_MASK = 2'd1;
    localparam logic [1:0] A_CTRL = 2'd2;
    localparam logic [1:0] A_STAT = 2'd3;

    state_t            state_q, state_d;
    logic [NSRC-1:0]   prev_q, prev_d;
    logic [NSRC-1:0]   pend_q, pend_d;
    logic [NSRC-1:0]   mask_q, mask_d;
    logic              gen_q, gen_d;
    logic              int_q, int_d;
    logic [IDW-1:0]    int_id_q, int_id_d;
    logic [NSRC-1:0]   src_ack_q, src_ack_d;
    logic [31:0]       rdt_q, rdt_d;
    logic              nwait_q, nwait_d;
    logic              rrdis_q;

    logic              bus_acc;
    logic              bus_wr;
    logic              bus_rd;
    logic [NSRC-1:0]   rise;
    logic [NSRC-1:0]   elig;
    logic [NSRC-1:0]   id_onehot;
    logic [NSRC-1:0]   clr_vec;
    logic              win_found;
    logic [IDW-1:0]    win_id;
    logic              unused_wdt;

    assign unused_wdt = ^WDT;

    // {found, index} of the lowest set bit
    function automatic logic [IDW:0] first_set(input logic [NSRC-1:0] v);
        logic [IDW:0] r;
        r = '0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (v[i]) begin
                r = {1'b1, i[IDW-1:0]};
            end
        end
        return r;
    endfunction

    function automatic logic [NSRC-1:0] onehot(input logic [IDW-1:0] id);
        logic [NSRC-1:0] r;
        r = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (id == i[IDW-1:0]) begin
                r[i] = 1'b1;
            end
        end
        return r;
    endfunction

    // A request arriving while the previous access completes is dropped
    assign bus_acc = REQ & ~nwait_q;
    assign bus_wr  = bus_acc & WT;
    assign bus_rd  = bus_acc & ~WT;

    assign rise      = SRC_INT & ~prev_q;
    assign elig      = gen_q ? (pend_q & mask_q) : '0;
    assign id_onehot = onehot(int_id_q);

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
`ifdef INTARB_RR_EN
    logic            rrdis_d;
    logic [IDW-1:0]  last_q, last_d;
    logic [IDW-1:0]  rr_start;
    logic [NSRC-1:0] rr_rot;
    logic [IDW:0]    rr_pick;
    logic [IDW:0]    rr_sum;
    logic [IDW:0]    fp_pick;

    always_comb begin
        rr_start  = (last_q == IDW'(NSRC - 1)) ? '0 : last_q + 1'b1;
        rr_rot    = NSRC'({elig, elig} >> rr_start);
        rr_pick   = first_set(rr_rot);
        rr_sum    = {1'b0, rr_pick[IDW-1:0]} + {1'b0, rr_start};
        if (rr_sum >= (IDW+1)'(NSRC)) begin
            rr_sum = rr_sum - (IDW+1)'(NSRC);
        end
        fp_pick   = first_set(elig);
        win_found = 1'b0;
        win_id    = '0;
        if (rrdis_q) begin
            win_found = fp_pick[IDW];
            win_id    = fp_pick[IDW-1:0];
        end else begin
            win_found = rr_pick[IDW];
            win_id    = rr_sum[IDW-1:0];
        end
    end

    always_comb begin
        last_d = last_q;
        if (state_q == S_IDLE && win_found) begin
            last_d = win_id;
        end
        rrdis_d = rrdis_q;
        if (bus_wr && ADDR == A_CTRL) begin
            rrdis_d = WDT[1];
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            last_q  <= IDW'(NSRC - 1);
            rrdis_q <= 1'b0;
        end else begin
            last_q  <= last_d;
            rrdis_q <= rrdis_d;
        end
    end
`else
    logic [IDW:0] fp_pick;

    assign rrdis_q   = 1'b0;
    assign fp_pick   = first_set(elig);
    assign win_found = fp_pick[IDW];
    assign win_id    = fp_pick[IDW-1:0];
`endif

    // ------------------------------------------------------------------
    // Registers and bus
    // ------------------------------------------------------------------
    always_comb begin
        prev_d  = SRC_INT;
        mask_d  = mask_q;
        gen_d   = gen_q;
        nwait_d = bus_acc;
        rdt_d   = '0;
        clr_vec = '0;
        if (bus_wr) begin
            case (ADDR)
                A_PEND:  clr_vec = WDT[NSRC-1:0];
                A_MASK:  mask_d  = WDT[NSRC-1:0];
                A_CTRL:  gen_d   = WDT[0];
                default: ;
            endcase
        end
        if (bus_rd) begin
            case (ADDR)
                A_PEND:  rdt_d = {{(32-NSRC){1'b0}}, pend_q};
                A_MASK:  rdt_d = {{(32-NSRC){1'b0}}, mask_q};
                A_CTRL:  rdt_d = {30'd0, rrdis_q, gen_q};
                A_STAT:  rdt_d = {(state_q != S_IDLE), {(31-IDW){1'b0}}, int_id_q};
                default: rdt_d = '0;
            endcase
        end
        if (state_q == S_ACKS) begin
            clr_vec = clr_vec | id_onehot;
        end
        // A fresh edge always beats a clear in the same cycle
        pend_d = (pend_q & ~clr_vec) | rise;
    end

    // ------------------------------------------------------------------
    // Service FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        int_d     = int_q;
        int_id_d  = int_id_q;
        src_ack_d = '0;
        case (state_q)
            S_IDLE: begin
                if (win_found) begin
                    state_d  = S_ASRT;
                    int_d    = 1'b1;
                    int_id_d = win_id;
                end
            end
            S_ASRT: begin
                if (INT_ACK) begin
                    state_d   = S_ACKS;
                    int_d     = 1'b0;
                    src_ack_d = id_onehot;
                end
            end
            S_ACKS: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                int_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q   <= S_IDLE;
            prev_q    <= '0;
            pend_q    <= '0;
            mask_q    <= '0;
            gen_q     <= 1'b0;
            int_q     <= 1'b0;
            int_id_q  <= '0;
            src_ack_q <= '0;
            rdt_q     <= '0;
            nwait_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            prev_q    <= prev_d;
            pend_q    <= pend_d;
            mask_q    <= mask_d;
            gen_q     <= gen_d;
            int_q     <= int_d;
            int_id_q  <= int_id_d;
            src_ack_q <= src_ack_d;
            rdt_q     <= rdt_d;
            nwait_q   <= nwait_d;
        end
    end

    assign RDT     = rdt_q;
    assign nWAIT   = nwait_q;
    assign SRC_ACK = src_ack_q;
    assign INT     = int_q;
    assign INT_ID  = int_id_q;

endmodule

`default_nettype wire

// File: tb/tb_int_arbiter.sv
// ============================================================================
//  Module   : tb_int_arbiter
//  Purpose  : Directed self-checking bench for int_arbiter.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_int_arbiter;

    logic        CLK;
    logic        nRST;
    logic        REQ;
    logic        WT;
    logic [1:0]  ADDR;
    logic [31:0] WDT;
    logic [31:0] RDT;
    logic        nWAIT;
    logic [5:0]  SRC_INT;
    logic [5:0]  SRC_ACK;
    logic        INT;
    logic [3:0]  INT_ID;
    logic        INT_ACK;

    int tests = 0;
    int fails = 0;
    logic [31:0] rd;

    int_arbiter #(.NSRC(6), .IDW(4)) dut (
        .CLK     (CLK),
        .nRST    (nRST),
        .REQ     (REQ),
        .WT      (WT),
        .ADDR    (ADDR),
        .WDT     (WDT),
        .RDT     (RDT),
        .nWAIT   (nWAIT),
        .SRC_INT (SRC_INT),
        .SRC_ACK (SRC_ACK),
        .INT     (INT),
        .INT_ID  (INT_ID),
        .INT_ACK (INT_ACK)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        REQ = 1'b1; WT = 1'b1; ADDR = a; WDT = d;
        tick();
        REQ = 1'b0; WT = 1'b0; WDT = '0;
        check("wr_nwait", {31'd0, nWAIT}, 32'd1);
        tick();
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        REQ = 1'b1; WT = 1'b0; ADDR = a;
        tick();
        d = RDT;
        REQ = 1'b0;
        check("rd_nwait", {31'd0, nWAIT}, 32'd1);
        tick();
        check("rd_rdt_idle", RDT, 32'd0);
    endtask

    task automatic wait_int();
        for (int n = 0; n < 20 && INT !== 1'b1; n++) begin
            tick();
        end
        check("int_timeout", {31'd0, INT}, 32'd1);
    endtask

    initial begin
        int rr_exp[4];
        rr_exp = '{0, 3, 0, 3};
        nRST = 1'b0; REQ = 1'b0; WT = 1'b0; ADDR = '0; WDT = '0;
        SRC_INT = '0; INT_ACK = 1'b0;
        #1;
        check("rst_int",   {31'd0, INT},     32'd0);
        check("rst_id",    {28'd0, INT_ID},  32'd0);
        check("rst_ack",   {26'd0, SRC_ACK}, 32'd0);
        check("rst_rdt",   RDT,              32'd0);
        check("rst_nwait", {31'd0, nWAIT},   32'd0);
        tick(); tick();
        nRST = 1'b1;
        tick();

        // T2 single IRQ
        bus_write(2'd1, 32'h3F);
        bus_write(2'd2, 32'h01);
        SRC_INT = 6'h04; tick();
        SRC_INT = 6'h00; tick();
        check("t2_int", {31'd0, INT}, 32'd1);
        check("t2_id",  {28'd0, INT_ID}, 32'd2);
        bus_read(2'd0, rd); check("t2_pend", rd, 32'h04);
        bus_read(2'd3, rd); check("t2_stat", rd, 32'h8000_0002);
        INT_ACK = 1'b1; tick(); INT_ACK = 1'b0;
        check("t2_acks_int", {31'd0, INT}, 32'd0);
        check("t2_srcack",   {26'd0, SRC_ACK}, 32'h04);
        tick();
        check("t2_srcack_off", {26'd0, SRC_ACK}, 32'h00);
        bus_read(2'd0, rd); check("t2_pend_clr", rd, 32'h00);
        INT_ACK = 1'b1; tick(); INT_ACK = 1'b0; tick();
        check("ack_idle_ignored", {26'd0, SRC_ACK}, 32'h00);
        check("ack_idle_int",     {31'd0, INT},     32'd0);

        // T3 fixed priority (RRDIS set so it also holds with round robin built in)
        bus_write(2'd2, 32'h03);
        bus_read(2'd2, rd);
`ifdef INTARB_RR_EN
        check("ctrl_rd", rd, 32'h03);
`else
        check("ctrl_rd", rd, 32'h01);
`endif
        SRC_INT = 6'h12; tick();
        SRC_INT = 6'h00; tick();
        check("t3_int1", {31'd0, INT}, 32'd1);
        check("t3_id1",  {28'd0, INT_ID}, 32'd1);
        INT_ACK = 1'b1; tick(); INT_ACK = 1'b0;
        check("t3_ack1", {26'd0, SRC_ACK}, 32'h02);
        check("t3_gap1", {31'd0, INT}, 32'd0);
        tick();
        check("t3_gap2", {31'd0, INT}, 32'd0);
        tick();
        check("t3_int2", {31'd0, INT}, 32'd1);
        check("t3_id2",  {28'd0, INT_ID}, 32'd4);
        INT_ACK = 1'b1; tick(); INT_ACK = 1'b0;
        check("t3_ack2", {26'd0, SRC_ACK}, 32'h10);
        tick();
        bus_write(2'd2, 32'h01);

        // T5 mask / GEN
        bus_write(2'd1, 32'h00);
        SRC_INT = 6'h20; tick();
        SRC_INT = 6'h00; tick(); tick();
        check("t5_masked_int", {31'd0, INT}, 32'd0);
        bus_read(2'd0, rd); check("t5_pend", rd, 32'h20);
        check("t5_masked_int2", {31'd0, INT}, 32'd0);
        bus_write(2'd1, 32'h20);
        check("t5_int", {31'd0, INT}, 32'd1);
        check("t5_id",  {28'd0, INT_ID}, 32'd5);
        bus_write(2'd2, 32'h00);
        check("t5_gen0_hold", {31'd0, INT}, 32'd1);
        bus_write(2'd0, 32'h20);
        bus_read(2'd0, rd); check("t5_w1c", rd, 32'h00);
        check("t5_w1c_hold", {31'd0, INT}, 32'd1);
        INT_ACK = 1'b1; tick(); INT_ACK = 1'b0;
        check("t5_ack", {26'd0, SRC_ACK}, 32'h20);
        tick();
        bus_write(2'd2, 32'h01);
        bus_write(2'd1, 32'h3F);

        // T6 collision during ACKS
        SRC_INT = 6'h04; tick();
        SRC_INT = 6'h00; tick();
        check("t6_id", {28'd0, INT_ID}, 32'd2);
        INT_ACK = 1'b1; tick(); INT_ACK = 1'b0;
        SRC_INT = 6'h04;
        check("t6_ack", {26'd0, SRC_ACK}, 32'h04);
        tick();
        SRC_INT = 6'h00;
        check("t6_gap", {31'd0, INT}, 32'd0);
        tick();
        check("t6_int2", {31'd0, INT}, 32'd1);
        check("t6_id2",  {28'd0, INT_ID}, 32'd2);
        bus_read(2'd0, rd); check("t6_pend", rd, 32'h04);
        INT_ACK = 1'b1; tick(); INT_ACK = 1'b0; tick();
        bus_read(2'd0, rd); check("t6_pend_clr", rd, 32'h00);

        // T1 reset in the middle of ASRT
        SRC_INT = 6'h08; tick();
        SRC_INT = 6'h00; tick();
        check("t1_pre_id", {28'd0, INT_ID}, 32'd3);
        nRST = 1'b0;
        #1;
        check("t1_int",  {31'd0, INT},     32'd0);
        check("t1_id",   {28'd0, INT_ID},  32'd0);
        check("t1_pend", {26'd0, dut.pend_q}, 32'd0);
        check("t1_mask", {26'd0, dut.mask_q}, 32'd0);
        tick();
        nRST = 1'b1;
        tick();
        bus_read(2'd3, rd); check("t1_stat", rd, 32'h0000_0000);
        bus_read(2'd2, rd); check("t1_ctrl", rd, 32'h0000_0000);

`ifdef INTARB_RR_EN
        // T4 round robin from a freshly reset pointer
        bus_write(2'd1, 32'h3F);
        bus_write(2'd2, 32'h01);
        SRC_INT = 6'h09; tick();
        SRC_INT = 6'h00;
        for (int k = 0; k < 4; k++) begin
            wait_int();
            check("t4_id", {28'd0, INT_ID}, rr_exp[k]);
            INT_ACK = 1'b1; tick(); INT_ACK = 1'b0;
            if (k < 2) begin
                SRC_INT = 6'b1 << rr_exp[k];
            end
            tick();
            SRC_INT = 6'h00;
        end
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
